// File: rtl/lfsr_rng_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_rng_pkg
// Shared types and helpers for the LFSR random-number arbiter.
//   arb_state_e    : arbiter FSM states (SERVE, WARMUP)
//   STATS_W        : width of the optional grant counter
//   FB_MAX_W       : widest LFSR the feedback helper supports
//   lfsr_feedback(): XOR-reduce of state masked by the tap vector
// -----------------------------------------------------------------------------
package lfsr_rng_pkg;

  typedef enum logic {
    SERVE  = 1'b0,
    WARMUP = 1'b1
  } arb_state_e;

  localparam int unsigned STATS_W  = 16;
  localparam int unsigned FB_MAX_W = 32;

  // Callers zero-extend state and taps to FB_MAX_W so the helper stays width-agnostic.
  function automatic logic lfsr_feedback(input logic [FB_MAX_W-1:0] state,
                                         input logic [FB_MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// -----------------------------------------------------------------------------
// lfsr_core
// Fibonacci LFSR: shifts left, feedback bit enters at bit 0.
// A load of all-zero is replaced by SEED so the lock-up state is unreachable.
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high; state returns to SEED
//   step_i     in   advance one LFSR state
//   load_i     in   load load_val_i (has priority over step_i)
//   load_val_i in   new state value
//   state_o    out  current LFSR state
// -----------------------------------------------------------------------------
module lfsr_core
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'hA,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0]    state_q, state_d;
  logic [FB_MAX_W-1:0] state_ext, taps_ext;

  always_comb begin
    state_ext                = '0;
    state_ext[WIDTH-1:0]     = state_q;
    taps_ext                 = '0;
    taps_ext[WIDTH-1:0]      = TAPS;
    state_d                  = state_q;
    if (load_i) begin
      state_d = (load_val_i == '0) ? SEED : load_val_i;
    end else if (step_i) begin
      state_d = {state_q[WIDTH-2:0], lfsr_feedback(state_ext, taps_ext)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// -----------------------------------------------------------------------------
// lfsr_rng_arbiter
// Shared pseudo-random source for NUM_REQ consumers. Round-robin arbitration,
// the LFSR advances once per grant. A reseed discards WARMUP_CYCLES states
// before serving again.
// Ports:
//   clk          in   clock
//   reset        in   asynchronous, active-high
//   req_i        in   per-requester request level, held until granted
//   gnt_o        out  one-hot grant, combinational
//   rnd_o        out  LFSR state while a grant is active, else 0
//   seed_we_i    in   load seed_i this cycle (blocks any grant)
//   seed_i       in   new seed (0 is replaced by SEED)
//   busy_o       out  high while in WARMUP
//   grant_cnt_o  out  saturating grant count (only with LFSR_RNG_ARB_STATS_EN)
// Optional feature macro: LFSR_RNG_ARB_STATS_EN
// -----------------------------------------------------------------------------
module lfsr_rng_arbiter
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned      NUM_REQ       = 4,
  parameter int unsigned      WIDTH         = 4,
  parameter logic [WIDTH-1:0] TAPS          = 4'hA,
  parameter logic [WIDTH-1:0] SEED          = '1,
  parameter int unsigned      WARMUP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [WIDTH-1:0]   rnd_o,
  input  logic               seed_we_i,
  input  logic [WIDTH-1:0]   seed_i,
  output logic               busy_o
`ifdef LFSR_RNG_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] grant_cnt_o
`endif
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q;
  logic [PW-1:0]      ptr_q;
  logic [7:0]         cnt_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      ptr_nxt;
  logic [PW:0]        cand;
  logic [WIDTH-1:0]   lfsr_state;
  logic               lfsr_step;

  // Scan NUM_REQ slots starting at the pointer; the extra bit in cand
  // absorbs the wrap before reducing modulo NUM_REQ.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == SERVE && !seed_we_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, ptr_q} + (PW+1)'(k);
        if (cand >= (PW+1)'(NUM_REQ)) begin
          cand = cand - (PW+1)'(NUM_REQ);
        end
        if (!gnt_any && req_i[cand[PW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[PW-1:0];
        end
      end
      if (gnt_any) begin
        gnt[gnt_idx] = 1'b1;
      end
    end
  end

  assign ptr_nxt   = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
  assign lfsr_step = gnt_any || (state_q == WARMUP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SERVE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (seed_we_i) begin
      cnt_q <= 8'(WARMUP_CYCLES);
      if (WARMUP_CYCLES == 0) begin
        state_q <= SERVE;
        busy_q  <= 1'b0;
      end else begin
        state_q <= WARMUP;
        busy_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        SERVE: begin
          if (gnt_any) begin
            ptr_q <= ptr_nxt;
          end
        end
        WARMUP: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_q <= SERVE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= SERVE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .step_i     (lfsr_step),
    .load_i     (seed_we_i),
    .load_val_i (seed_i),
    .state_o    (lfsr_state)
  );

  assign gnt_o  = gnt;
  assign rnd_o  = gnt_any ? lfsr_state : '0;
  assign busy_o = busy_q;

`ifdef LFSR_RNG_ARB_STATS_EN
  logic [STATS_W-1:0] grant_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt_q <= '0;
    end else if (gnt_any && (grant_cnt_q != '1)) begin
      grant_cnt_q <= grant_cnt_q + STATS_W'(1);
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
module tb_lfsr_rng_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] rnd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] rnd;
  logic       seed_we;
  logic [3:0] seed;
  logic       busy;
`ifdef LFSR_RNG_ARB_STATS_EN
  logic [15:0] grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  lfsr_rng_arbiter #(
    .NUM_REQ       (4),
    .WIDTH         (4),
    .TAPS          (4'hA),
    .SEED          (4'hF),
    .WARMUP_CYCLES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .gnt_o     (gnt),
    .rnd_o     (rnd),
    .seed_we_i (seed_we),
    .seed_i    (seed),
    .busy_o    (busy)
`ifdef LFSR_RNG_ARB_STATS_EN
    ,
    .grant_cnt_o (grant_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [3:0] r);
    exp_t e;
    e.gnt = g;
    e.rnd = r;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_busy(input logic exp_busy);
    @(negedge clk);
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every granted cycle pops one expectation; idle cycles must show rnd 0.
  always @(negedge clk) begin
    if (!reset) begin
      if (gnt != 4'b0000) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: gnt=%b rnd=%h with empty scoreboard at %0t", gnt, rnd, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("grant_rnd", {24'd0, gnt, rnd}, {24'd0, e.gnt, e.rnd});
        end
      end else begin
        chk("idle_rnd", {28'd0, rnd}, 32'd0);
      end
    end
  end

  initial begin
    logic [3:0] seq1 [7];
    seq1 = '{4'hF, 4'hE, 4'hC, 4'h9, 4'h3, 4'h7, 4'hF};

    reset   = 1'b1;
    req     = '0;
    seed_we = 1'b0;
    seed    = '0;
    tick();
    chk("reset_gnt", {28'd0, gnt}, 32'd0);
    chk("reset_rnd", {28'd0, rnd}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;

    // Single requester: full LFSR period from F
    req = 4'b0001;
    for (int i = 0; i < 7; i++) push(4'b0001, seq1[i]);
    for (int i = 0; i < 7; i++) tick();
    req = '0;
    tick();

    // Round-robin over all four
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    push(4'b0001, 4'hF);
    push(4'b0010, 4'hE);
    push(4'b0100, 4'hC);
    push(4'b1000, 4'h9);
    push(4'b0001, 4'h3);
    for (int i = 0; i < 5; i++) tick();
    req = '0;
    tick();

    // Reseed with 9 while requesting: seed beats req, two warm-up steps 9->3->7
    seed_we = 1'b1;
    seed    = 4'h9;
    req     = 4'b0001;
    #1;
    chk("seed_beats_req", {28'd0, gnt}, 32'd0);
    tick_busy(1'b0);
    seed_we = 1'b0;
    tick_busy(1'b1);
    tick_busy(1'b1);
    push(4'b0001, 4'h7);
    push(4'b0001, 4'hF);
    tick_busy(1'b0);
    tick_busy(1'b0);
    req = '0;
    tick();

    // Zero seed is replaced by F: F->E->C discarded, first grant is C
    seed_we = 1'b1;
    seed    = 4'h0;
    tick_busy(1'b0);
    seed_we = 1'b0;
    tick_busy(1'b1);
    tick_busy(1'b1);
    req = 4'b0001;
    push(4'b0001, 4'hC);
    push(4'b0001, 4'h9);
    tick_busy(1'b0);
    tick_busy(1'b0);
    req = '0;
    tick();

    // Reseed during warm-up restarts the count: 3->7->F
    seed_we = 1'b1;
    seed    = 4'h9;
    tick_busy(1'b0);
    seed    = 4'h3;
    tick_busy(1'b1);
    seed_we = 1'b0;
    tick_busy(1'b1);
    tick_busy(1'b1);
    req = 4'b0010;
    push(4'b0010, 4'hF);
    push(4'b0010, 4'hE);
    tick_busy(1'b0);
    tick_busy(1'b0);
    req = '0;
    tick();

    // Asynchronous reset in the middle of warm-up
    seed_we = 1'b1;
    seed    = 4'h5;
    tick_busy(1'b0);
    seed_we = 1'b0;
    @(negedge clk);
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_gnt", {28'd0, gnt}, 32'd0);
    tick();
    reset = 1'b0;

    // Sparse requests from pointer 0 with LFSR back at F
    req = 4'b1010;
    push(4'b0010, 4'hF);
    push(4'b1000, 4'hE);
    push(4'b0010, 4'hC);
    for (int i = 0; i < 3; i++) tick();
    req = '0;
    tick();
`ifdef LFSR_RNG_ARB_STATS_EN
    chk("grant_cnt", {16'd0, grant_cnt}, 32'd3);
`endif
    tick();
    tick();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000 reached");
    $fatal(1, "timeout");
  end

endmodule
